// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a valid/ready output.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 mid-bit vote.
module uart_rx_param #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int CLKS_PER_TICK = 1,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int DW   = (CLKS_PER_TICK > 1) ?
                        $clog2(CLKS_PER_TICK) : 1;
  localparam int BW   = 4;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_e;

  state_e state_q, state_d;

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rx_s;

  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;

  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 fpend_q, fpend_d;
  logic                 ppend_q, ppend_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] smp_q, smp_d;
`else
  logic [0:0] smp_q, smp_d;
`endif

  logic active;
  logic tick_en;
  logic decide;
  logic bit_val;
  logic fall;
  logic last_data;
  logic last_stop;
  logic brk;
  logic comp;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;

  assign active = (state_q == START) || (state_q == DATA) ||
                  (state_q == PARITY) || (state_q == STOP);

  assign tick_en = (div_q == DW'(CLKS_PER_TICK - 1));
  assign decide  = active && tick_en &&
                   (tick_q == TW'(HALF + 1));

`ifdef UART_RX_MAJORITY_VOTE_EN
  assign bit_val = (smp_q[1] & smp_q[0]) |
                   (smp_q[1] & rx_s) |
                   (smp_q[0] & rx_s);
`else
  assign bit_val = smp_q[0];
`endif

  assign last_data = (bit_q == BW'(DATA_BITS - 1));
  assign last_stop = (bit_q == BW'(STOP_BITS - 1));
  assign brk  = ~bit_val && (bit_q == '0);
  assign comp = (state_q == STOP) && decide &&
                (last_stop || ~bit_val);

  // Two-flop synchroniser plus previous value for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      prev_q <= sync_q[1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (fall) state_d = START;
      START:  if (decide) state_d = bit_val ? IDLE : DATA;
      DATA: begin
        if (decide && last_data)
          state_d = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: if (decide) state_d = STOP;
      STOP: begin
        if (decide) begin
          if (brk)            state_d = BREAK;
          else if (last_stop) state_d = IDLE;
        end
      end
      BREAK:  if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, shift register, flags and output handshake.
  always_comb begin
    div_d   = div_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    fpend_d = fpend_q;
    ppend_d = ppend_q;
    smp_d   = smp_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = 1'b0;

    if (!active) begin
      div_d   = '0;
      tick_d  = '0;
      bit_d   = '0;
      fpend_d = 1'b0;
      ppend_d = 1'b0;
    end else begin
      div_d = tick_en ? '0 : div_q + 1'b1;
      if (tick_en) begin
        tick_d = (tick_q == TW'(OVERSAMPLE - 1)) ?
                 '0 : tick_q + 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
        smp_d = {smp_q[0], rx_s};
`else
        smp_d = rx_s;
`endif
      end
    end

    if (decide) begin
      unique case (state_q)
        START: bit_d = '0;
        DATA: begin
          sh_d  = {bit_val, sh_q[DATA_BITS-1:1]};
          bit_d = last_data ? '0 : bit_q + 1'b1;
        end
        PARITY: begin
          ppend_d = (^sh_q) ^ bit_val ^ (PARITY_MODE == 2);
        end
        STOP: begin
          bit_d = bit_q + 1'b1;
          if (!bit_val) fpend_d = 1'b1;
        end
        default: bit_d = bit_q;
      endcase
    end

    if (comp) begin
      done_d = 1'b1;
      ferr_d = fpend_q | ~bit_val;
      perr_d = ppend_q;
      if (!valid_q || ready) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      fpend_q <= 1'b0;
      ppend_q <= 1'b0;
      smp_q   <= '1;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      fpend_q <= fpend_d;
      ppend_q <= ppend_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign done       = done_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param.
// Default instance plus an even-parity instance on a second line.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int BIT_NS = 160;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic rx_p = 1'b1;
  logic ready = 1'b1;

  logic [7:0] data, data_p;
  logic valid, done, ferr, perr, ovr;
  logic valid_p, done_p, ferr_p, perr_p, ovr_p;

  uart_rx_param dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .valid(valid), .ready(ready),
    .done(done), .frame_err(ferr),
    .parity_err(perr), .overrun(ovr)
  );

  uart_rx_param #(.PARITY_MODE(1)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p),
    .data(data_p), .valid(valid_p), .ready(ready),
    .done(done_p), .frame_err(ferr_p),
    .parity_err(perr_p), .overrun(ovr_p)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int done_cnt = 0;
  int ovr_cnt = 0;
  int pulse_dbl = 0;
  int vrun = 0;
  int last_vrun = 0;
  logic [7:0] last_data;
  logic last_ferr, last_perr;
  logic done_prev = 1'b0;
  logic ovr_prev = 1'b0;

  int done_cnt_p = 0;
  logic [7:0] last_data_p;
  logic last_perr_p;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      last_data = data;
      last_ferr = ferr;
      last_perr = perr;
    end
    if (ovr) ovr_cnt++;
    if ((done && done_prev) || (ovr && ovr_prev)) pulse_dbl++;
    done_prev = done;
    ovr_prev = ovr;
    if (valid) vrun++;
    else if (vrun != 0) begin
      last_vrun = vrun;
      vrun = 0;
    end
    if (done_p) begin
      done_cnt_p++;
      last_data_p = data_p;
      last_perr_p = perr_p;
    end
  end

  task automatic drive(input bit line, input logic v);
    if (line) rx_p = v;
    else rx = v;
  endtask

  // Serial frame, LSB first; the line is left at the stop level.
  task automatic send_frame(input bit line, input logic [7:0] b,
                            input bit has_par, input logic pbit,
                            input logic stopb);
    drive(line, 1'b0);
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      drive(line, b[i]);
      #(BIT_NS);
    end
    if (has_par) begin
      drive(line, pbit);
      #(BIT_NS);
    end
    drive(line, stopb);
    #(BIT_NS);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #37;
    checks++;
    if (data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h exp=00", data);
    end
    checks++;
    if ({valid, done, ferr, perr, ovr} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {valid, done, ferr, perr, ovr});
    end
    checks++;
    if ({data_p, valid_p, done_p, perr_p} !== 11'b0) begin
      failures++;
      $display("FAIL reset_par_inst got=%h exp=0",
               {data_p, valid_p, done_p, perr_p});
    end
    @(negedge clk);
    rst = 1'b1;
    #(BIT_NS);
  endtask

  task automatic test_basic();
    int d0, o0;
    d0 = done_cnt;
    o0 = ovr_cnt;
    ready = 1'b1;
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    #(2 * BIT_NS);
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL basic_done got=%0d exp=1", done_cnt - d0);
    end
    checks++;
    if (last_data !== 8'hA5) begin
      failures++;
      $display("FAIL basic_data got=%h exp=a5", last_data);
    end
    checks++;
    if (last_vrun !== 1) begin
      failures++;
      $display("FAIL basic_valid_len got=%0d exp=1", last_vrun);
    end
    checks++;
    if ({last_ferr, last_perr} !== 2'b00 || ovr_cnt != o0) begin
      failures++;
      $display("FAIL basic_errs got=%b%b ovr=%0d exp=00 0",
               last_ferr, last_perr, ovr_cnt - o0);
    end
  endtask

  task automatic test_parity();
    logic [7:0] b;
    logic pb, exp_err;
    send_frame(1, 8'h5A, 1, 1'b1, 1'b1);
    #(BIT_NS);
    checks++;
    if (last_data_p !== 8'h5A || last_perr_p !== 1'b1) begin
      failures++;
      $display("FAIL parity_bad got=%h/%b exp=5a/1",
               last_data_p, last_perr_p);
    end
    send_frame(1, 8'h5A, 1, 1'b0, 1'b1);
    #(BIT_NS);
    checks++;
    if (last_perr_p !== 1'b0) begin
      failures++;
      $display("FAIL parity_good got=%b exp=0", last_perr_p);
    end
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      pb = 1'($urandom);
      exp_err = (($countones(b) + int'(pb)) % 2) != 0;
      send_frame(1, b, 1, pb, 1'b1);
      #($urandom_range(0, 200));
      checks++;
      if (last_data_p !== b || last_perr_p !== exp_err) begin
        failures++;
        $display("FAIL parity_rand%0d got=%h/%b exp=%h/%b",
                 k, last_data_p, last_perr_p, b, exp_err);
      end
    end
    checks++;
    if (done_cnt_p !== 10) begin
      failures++;
      $display("FAIL parity_count got=%0d exp=10", done_cnt_p);
    end
  endtask

  task automatic test_glitch();
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    rx = 1'b0;
    #30;
    rx = 1'b1;
    #(3 * BIT_NS);
    checks++;
    if (done_cnt - d0 !== 0) begin
      failures++;
      $display("FAIL glitch_nodone got=%0d exp=0", done_cnt - d0);
    end
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    #(BIT_NS);
    checks++;
    if (done_cnt - d0 !== 1 || last_data !== 8'h3C) begin
      failures++;
      $display("FAIL glitch_next got=%0d/%h exp=1/3c",
               done_cnt - d0, last_data);
    end
  endtask

  task automatic test_break();
    int d0;
    d0 = done_cnt;
    send_frame(0, 8'hFF, 0, 1'b0, 1'b0);
    #400;
    checks++;
    if (done_cnt - d0 !== 1 || last_ferr !== 1'b1 ||
        last_data !== 8'hFF) begin
      failures++;
      $display("FAIL break_frame got=%0d/%b/%h exp=1/1/ff",
               done_cnt - d0, last_ferr, last_data);
    end
    rx = 1'b1;
    #(2 * BIT_NS);
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL break_quiet got=%0d exp=1", done_cnt - d0);
    end
    send_frame(0, 8'h01, 0, 1'b0, 1'b1);
    #(BIT_NS);
    checks++;
    if (last_data !== 8'h01 || last_ferr !== 1'b0 ||
        done_cnt - d0 !== 2) begin
      failures++;
      $display("FAIL break_recover got=%h/%b/%0d exp=01/0/2",
               last_data, last_ferr, done_cnt - d0);
    end
  endtask

  task automatic test_overrun();
    int d0, o0;
    d0 = done_cnt;
    o0 = ovr_cnt;
    @(negedge clk);
    ready = 1'b0;
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    #(BIT_NS);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1);
    #(2 * BIT_NS);
    checks++;
    if (data !== 8'h11 || valid !== 1'b1) begin
      failures++;
      $display("FAIL ovr_hold got=%h/%b exp=11/1", data, valid);
    end
    checks++;
    if (done_cnt - d0 !== 2 || ovr_cnt - o0 !== 1) begin
      failures++;
      $display("FAIL ovr_pulse got=done%0d ovr%0d exp=done2 ovr1",
               done_cnt - d0, ovr_cnt - o0);
    end
    checks++;
    if (last_data !== 8'h11) begin
      failures++;
      $display("FAIL ovr_data_at_done got=%h exp=11", last_data);
    end
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || data !== 8'h11) begin
      failures++;
      $display("FAIL ovr_drain got=%b/%h exp=0/11", valid, data);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [7:0] b;
    b = 8'hC3;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = b[4];
    #(BIT_NS / 2);
    rst = 1'b0;
    rx = 1'b1;
    #100;
    checks++;
    if (data !== 8'h00 || valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear got=%h/%b exp=00/0", data, valid);
    end
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    #(2 * BIT_NS);
    checks++;
    if (done_cnt - d0 !== 0) begin
      failures++;
      $display("FAIL midrst_nodone got=%0d exp=0", done_cnt - d0);
    end
    send_frame(0, 8'h96, 0, 1'b0, 1'b1);
    #(BIT_NS);
    checks++;
    if (last_data !== 8'h96 || done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL midrst_next got=%h/%0d exp=96/1",
               last_data, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [7:0] b;
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      d0 = done_cnt;
      b = 8'($urandom);
      send_frame(0, b, 0, 1'b0, 1'b1);
      checks++;
      if (last_data !== b || done_cnt - d0 !== 1 ||
          last_ferr !== 1'b0) begin
        failures++;
        $display("FAIL b2b%0d got=%h/%0d/%b exp=%h/1/0",
                 k, last_data, done_cnt - d0, last_ferr, b);
      end
      if (k % 4 == 3) #($urandom_range(0, 300));
    end
    #(BIT_NS);
    checks++;
    if (pulse_dbl !== 0) begin
      failures++;
      $display("FAIL pulse_width got=%0d exp=0", pulse_dbl);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit, even, legal 8..64.
REQ-003 The block SHALL have parameter CLKS_PER_TICK, default 1, clk cycles per sample tick, legal >=1.
REQ-004 The block SHALL have parameter PARITY_MODE, default 0, where 0 is none, 1 is even and 2 is odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, legal 1..2.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-008 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 The block SHALL have port data, output, DATA_BITS wide: last received word, LSB = first data bit.
REQ-010 The block SHALL have port valid, output, 1 bit: data holds an unconsumed word.
REQ-011 The block SHALL have port ready, input, 1 bit: consumer accepts data when valid && ready.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-013 The block SHALL have ports frame_err, parity_err and overrun, outputs, 1 bit each: error flags.

Function
REQ-014 The block SHALL pass rx through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-015 The block SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-016 In IDLE, a synchronised 1->0 transition SHALL go to START and reset the tick and bit counters.
REQ-017 In START, the line SHALL be sampled at tick OVERSAMPLE/2; a 1 aborts to IDLE with no flags and no done; a 0 goes to DATA.
REQ-018 In DATA, DATA_BITS bits SHALL be sampled, LSB first, each exactly OVERSAMPLE ticks after the previous sample.
REQ-019 PARITY SHALL be entered only if PARITY_MODE != 0; a mismatch against even/odd parity of the data sets the parity error.
REQ-020 STOP SHALL sample STOP_BITS bits; any sampled 0 sets the frame error.
REQ-021 One clk after the last stop sample, done SHALL pulse for exactly 1 cycle and frame_err/parity_err SHALL update to the current frame's status; both hold until the next done.
REQ-022 If the first stop sample is 0, the FSM SHALL enter BREAK and return to IDLE only after rx is sampled high; no new start is detected in BREAK.
REQ-023 At frame completion with valid=0, or with valid=1 and ready=1 in that same cycle, data SHALL load and valid SHALL be 1 on the next cycle.
REQ-024 At frame completion with valid=1 and ready=0, data SHALL be kept, the new word dropped, and overrun pulsed high for 1 cycle.
REQ-025 When valid && ready with no completion in that cycle, valid SHALL clear on the next cycle; data holds its value.
REQ-026 The bit period SHALL be OVERSAMPLE*CLKS_PER_TICK clk cycles; defaults give 16 clk/bit.

Reset
REQ-027 While rst=0, the FSM SHALL be IDLE, the synchroniser SHALL be 1s, and all counters SHALL be 0.
REQ-028 While rst=0, data SHALL be 0 and valid, done, frame_err, parity_err and overrun SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame, with no done after release.
REQ-030 After release, a frame SHALL be detected only from a fresh falling edge of the synchronised rx.

Configuration
REQ-031 The block SHALL use macro UART_RX_MAJORITY_VOTE_EN.
REQ-032 With UART_RX_MAJORITY_VOTE_EN defined, each bit value SHALL be the 2-of-3 majority of ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; START validation SHALL also use the vote.
REQ-033 Without UART_RX_MAJORITY_VOTE_EN, each bit value SHALL be the single sample at tick OVERSAMPLE/2; timing is identical in both builds.

Verification
REQ-034 Defaults, 100 MHz clk, ready=1, frame 0xA5 at 160 ns/bit -> one done pulse, data=8'hA5, valid high for 1 cycle, all errors 0.
REQ-035 PARITY_MODE=1, frame 0x5A sent with parity bit 1 -> data=8'h5A, parity_err=1; the same frame with parity bit 0 -> parity_err=0.
REQ-036 rx low for 3 clk then high (glitch) -> no done, FSM back in IDLE; a following 0x3C frame is received correctly.
REQ-037 Frame 0xFF with stop bit 0, then rx low for 40 clk -> done, frame_err=1, no new frame until rx high; then 0x01 -> data=8'h01, frame_err=0.
REQ-038 ready=0, frames 0x11 then 0x22 -> data=8'h11 and valid=1 retained, overrun 1-cycle pulse at second done; set ready=1 -> valid clears.
REQ-039 rst=0 at the mid-point of data bit 4 of 0xC3, release, then send 0x96 -> no done for 0xC3; data=8'h96.
